// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM encoding (IDLE / REQ / WAIT)
//   fetch_entry_t : one queued instruction word with its address
//   PC_STEP       : byte increment between sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the fetch unit's bus signals: instruction-memory port, the
// DataPath instruction port, the redirect input and a debug view of the FSM.
//   master : fetch unit side
//   slave  : environment side (memory + DataPath)
//
// Handshakes:
//   imemReq/imemAck : imemReq is high for exactly one cycle and is accepted in
//     that cycle; imemAck (with imemRdata) returns 1..N cycles later, never in
//     the request cycle, at most once per request, one request outstanding.
//   instValid/instReady : the head {instruction, instPc} transfers in any
//     cycle where instValid & instReady; instReady is ignored while
//     instValid=0, and instValid never depends on instReady.
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic         imemReq;
  logic [31:0]  imemAddr;
  logic         imemAck;
  logic [31:0]  imemRdata;
  logic         instValid;
  logic [31:0]  instruction;
  logic [31:0]  instPc;
  logic         instReady;
  logic         redirect;
  logic [31:0]  redirectPc;
  fetch_state_t dbg_state;

  modport master (
    output imemReq, imemAddr, instValid, instruction, instPc, dbg_state,
    input  imemAck, imemRdata, instReady, redirect, redirectPc
  );

  modport slave (
    input  imemReq, imemAddr, instValid, instruction, instPc, dbg_state,
    output imemAck, imemRdata, instReady, redirect, redirectPc
  );

endinterface

// File: rtl/inst_queue.sv
// Small circular FIFO of fetch_entry_t between the memory port and the
// DataPath. Flush wins over push/pop. Head reads as all-zero while empty.
// Ports:
//   clock, resetN     : clock, async active-low reset
//   push, push_data   : enqueue (ignored when full and not popping)
//   pop               : dequeue head (ignored when empty)
//   flush             : drop all entries
//   head              : current head entry (zero when empty)
//   count             : number of valid entries
module inst_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to
// instruction memory, queues returned words and presents {instruction, PC}
// to the DataPath. A redirect flushes everything fetched so far; an
// in-flight read at that moment is marked for discard.
// Optional build macro FETCH_PERF_EN adds fetchStallCount (cycles with
// instReady=1 & instValid=0) and flushCount (redirect pulses), saturating.
// Ports:
//   clock, resetN   : clock, async active-low reset
//   bus (master)    : memory port, DataPath port, redirect, debug state
//   fetchStallCount : (FETCH_PERF_EN) starved-cycle counter
//   flushCount      : (FETCH_PERF_EN) redirect counter
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clock,
  input  logic               resetN,
  inst_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetchStallCount,
  output logic [15:0]        flushCount
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CA_W  = CNT_W + 1;

  fetch_state_t     state;
  logic [31:0]      fetch_pc;
  logic             discard;
  logic             req_q;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             head_valid;
  logic             ack_live;
  logic             push;
  logic             pop;
  logic             slot_now;
  logic             slot_after;
  logic [CA_W-1:0]  count_after;
  logic             unused_pc_bits;

  assign unused_pc_bits = &{1'b0, bus.redirectPc[1:0]};

  assign head_valid = (q_count != '0);
  assign ack_live   = (state == WAIT) && bus.imemAck;
  // Redirect kills both the returning word and any DataPath pop this cycle.
  assign push       = ack_live && !discard && !bus.redirect;
  assign pop        = head_valid && bus.instReady && !bus.redirect;

  assign push_entry.instr = bus.imemRdata;
  assign push_entry.pc    = fetch_pc;

  // The in-flight request holds a slot, so the queue only needs to be
  // checked against DEPTH when deciding to issue the next request.
  assign slot_now    = (q_count < CNT_W'(DEPTH));
  assign count_after = {1'b0, q_count} + CA_W'(push) - CA_W'(pop);
  assign slot_after  = (count_after < CA_W'(DEPTH));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      req_q    <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirectPc[31:2], 2'b00};
      if ((state == REQ) || ((state == WAIT) && !bus.imemAck)) begin
        // Old request still outstanding: swallow its ack.
        state   <= WAIT;
        discard <= 1'b1;
        req_q   <= 1'b0;
      end else begin
        // Idle, or the ack arriving now retires the old request.
        state   <= REQ;
        discard <= 1'b0;
        req_q   <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (slot_now) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          req_q <= 1'b0;
        end
        WAIT: begin
          if (bus.imemAck) begin
            if (!discard) fetch_pc <= fetch_pc + PC_STEP;
            discard <= 1'b0;
            if (slot_after) begin
              state <= REQ;
              req_q <= 1'b1;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (q_count)
  );

  assign bus.imemReq     = req_q;
  assign bus.imemAddr    = fetch_pc;
  assign bus.instValid   = head_valid;
  assign bus.instruction = head.instr;
  assign bus.instPc      = head.pc;
  assign bus.dbg_state   = state;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fetchStallCount <= '0;
      flushCount      <= '0;
    end else begin
      if (bus.instReady && !head_valid && (fetchStallCount != '1))
        fetchStallCount <= fetchStallCount + 32'd1;
      if (bus.redirect && (flushCount != '1))
        flushCount <= flushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clock;
  logic resetN;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  inst_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_stall_count;
  logic [15:0] flush_count;
`endif

  inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clock           (clock),
    .resetN          (resetN),
    .bus             (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetchStallCount (fetch_stall_count),
    .flushCount      (flush_count)
`endif
  );

  // ---------------- bench state / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc;        // address the next presented head must carry
  logic [31:0] req_log[$];    // request addresses since last clear
  logic [31:0] cons_log[$];   // consumed PCs since last clear
  logic [31:0] req_addr;
  int          pending;
  int          cnt;
  int          cyc;
  int          first_valid;
  int          n_consumed;
  int          lat_min, lat_max;
  int          ready_pct, redir_pct;
  int          redir_when;    // 0 random, 1 WAIT w/o ack, 2 WAIT with ack, 3 now
  logic [31:0] redir_target;
  int          redir_fired;
  int          stall_model;
  int          flush_model;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset(input logic stray_ack);
    resetN          = 1'b0;
    bus.imemAck     = stray_ack;
    bus.imemRdata   = 32'hDEAD_BEEF;
    bus.instReady   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirectPc  = '0;
    pending     = 0;
    cnt         = 0;
    exp_pc      = RST_PC;
    stall_model = 0;
    flush_model = 0;
    first_valid = -1;
    redir_when  = 0;
    req_log.delete();
    cons_log.delete();
    repeat (3) @(posedge clock);
    #1;
    resetN = 1'b1;   // stray ack (if any) stays up through this IDLE cycle
    cyc    = 0;
  endtask

  // One clock: sample this cycle's outputs, check, then drive this cycle's
  // inputs from the memory model and the random/directed stimulus knobs.
  task automatic step();
    logic        ack_now;
    logic        rd;
    logic        rdir;
    logic        valid;
    logic [31:0] tgt;
    logic [31:0] rdata;
    @(posedge clock);
    #1;
    cyc++;
    valid = bus.instValid;
`ifdef FETCH_PERF_EN
    check_eq("stall_count", fetch_stall_count, stall_model);
    check_eq("flush_count", {16'h0, flush_count}, flush_model[31:0] & 32'hFFFF);
`endif
    if (valid) begin
      check_eq("head_pc", bus.instPc, exp_pc);
      check_eq("head_instr", bus.instruction, mem_word(exp_pc));
      if (first_valid < 0) first_valid = cyc;
    end else begin
      check_eq("empty_pc", bus.instPc, 32'h0);
      check_eq("empty_instr", bus.instruction, 32'h0);
    end

    ack_now = 1'b0;
    if (pending != 0) begin
      if (cnt == 0) begin
        ack_now = 1'b1;
        pending = 0;
      end else begin
        cnt--;
      end
    end
    rdata = ack_now ? mem_word(req_addr) : $urandom();

    if (bus.imemReq) begin
      check_eq("one_outstanding", 32'(pending) | 32'(ack_now), 32'h0);
      check_eq("addr_align", 32'(bus.imemAddr[1:0]), 32'h0);
      pending  = 1;
      cnt      = $urandom_range(lat_max, lat_min) - 1;
      req_addr = bus.imemAddr;
      req_log.push_back(bus.imemAddr);
    end

    rd   = ($urandom_range(99, 0) < ready_pct);
    tgt  = $urandom();
    rdir = 1'b0;
    case (redir_when)
      1: rdir = (bus.dbg_state == WAIT) && !ack_now;
      2: rdir = (bus.dbg_state == WAIT) && ack_now;
      3: rdir = 1'b1;
      default: rdir = ($urandom_range(99, 0) < redir_pct);
    endcase
    if (rdir && (redir_when != 0)) begin
      tgt        = redir_target;
      redir_when = 0;
      redir_fired++;
      req_log.delete();
      cons_log.delete();
    end

    bus.imemAck    = ack_now;
    bus.imemRdata  = rdata;
    bus.instReady  = rd;
    bus.redirect   = rdir;
    bus.redirectPc = tgt;

    if (valid && rd && !rdir) begin
      cons_log.push_back(exp_pc);
      n_consumed++;
      exp_pc = exp_pc + 32'd4;
    end
    if (rdir) begin
      exp_pc = {tgt[31:2], 2'b00};
      flush_model++;
    end
    if (rd && !valid) stall_model++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    resetN = 1'b0;
    redir_fired = 0;
    n_consumed  = 0;
    lat_min = 1; lat_max = 1; ready_pct = 100; redir_pct = 0;

    // T1: sequential fetch from reset, 1-cycle memory, DataPath always ready
    apply_reset(1'b0);
    repeat (12) step();
    check_eq("t1_first_valid_cyc", first_valid, 3);
    check_eq("t1_pc0", cons_log[0], 32'h100);
    check_eq("t1_pc1", cons_log[1], 32'h104);
    check_eq("t1_pc2", cons_log[2], 32'h108);

    // T2: back-pressure fills the queue, fetch stops, release drains in order
    ready_pct = 0;
    apply_reset(1'b0);
    repeat (12) step();
    check_eq("t2_state_idle", 32'(bus.dbg_state), 32'(IDLE));
    check_eq("t2_no_req", 32'(bus.imemReq), 32'h0);
    check_eq("t2_valid_held", 32'(bus.instValid), 32'h1);
    check_eq("t2_head_pc", bus.instPc, 32'h100);
    ready_pct = 100;
    step();
    step();
    check_eq("t2_next_valid", 32'(bus.instValid), 32'h1);
    check_eq("t2_next_pc", bus.instPc, 32'h104);
    for (int i = 0; i < 20 && cons_log.size() < 3; i++) step();
    check_eq("t2_third_pc", cons_log[2], 32'h108);

    // T3: two redirects while waiting on memory; last target wins
    lat_min = 3; lat_max = 3;
    apply_reset(1'b0);
    redir_fired = 0;
    repeat (3) step();
    redir_target = 32'h303; redir_when = 1;
    for (int i = 0; i < 20 && redir_fired < 1; i++) step();
    redir_target = 32'h203; redir_when = 1;
    for (int i = 0; i < 20 && redir_fired < 2; i++) step();
    check_eq("t3_redirects_fired", redir_fired, 2);
    for (int i = 0; i < 30 && (req_log.size() < 1 || cons_log.size() < 1); i++) step();
    check_eq("t3_req_addr", req_log[0], 32'h200);
    check_eq("t3_first_pc", cons_log[0], 32'h200);

    // T4: redirect in the same cycle as the ack
    lat_min = 1; lat_max = 1;
    redir_fired = 0;
    repeat (4) step();
    redir_target = 32'h400; redir_when = 2;
    for (int i = 0; i < 20 && redir_fired < 1; i++) step();
    check_eq("t4_redirect_fired", redir_fired, 1);
    step();
    check_eq("t4_req_next", 32'(bus.imemReq), 32'h1);
    check_eq("t4_req_addr", bus.imemAddr, 32'h400);
    step();
    step();
    check_eq("t4_valid", 32'(bus.instValid), 32'h1);
    check_eq("t4_pc", bus.instPc, 32'h400);

    // T5: PC wraps modulo 2^32
    redir_fired = 0;
    redir_target = 32'hFFFF_FFFC; redir_when = 3;
    step();
    for (int i = 0; i < 30 && (req_log.size() < 2 || cons_log.size() < 2); i++) step();
    check_eq("t5_req0", req_log[0], 32'hFFFF_FFFC);
    check_eq("t5_req1", req_log[1], 32'h0);
    check_eq("t5_pc0", cons_log[0], 32'hFFFF_FFFC);
    check_eq("t5_pc1", cons_log[1], 32'h0);

    // T6: asynchronous reset while a read is outstanding, then a stray ack
    lat_min = 3; lat_max = 3; ready_pct = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 30 && !(bus.dbg_state == WAIT && bus.instValid); i++) step();
    check_eq("t6_in_wait", 32'(bus.dbg_state), 32'(WAIT));
    #1;
    resetN = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(bus.instValid), 32'h0);
    check_eq("t6_rst_req", 32'(bus.imemReq), 32'h0);
    check_eq("t6_rst_pc", bus.instPc, 32'h0);
    check_eq("t6_rst_instr", bus.instruction, 32'h0);
    check_eq("t6_rst_addr", bus.imemAddr, RST_PC);
    check_eq("t6_rst_state", 32'(bus.dbg_state), 32'(IDLE));
`ifdef FETCH_PERF_EN
    check_eq("t6_rst_stall", fetch_stall_count, 32'h0);
    check_eq("t6_rst_flush", {16'h0, flush_count}, 32'h0);
`endif
    lat_min = 1; lat_max = 1; ready_pct = 100;
    apply_reset(1'b1);
    repeat (6) step();
    check_eq("t6_first_valid_cyc", first_valid, 3);
    check_eq("t6_first_pc", cons_log[0], 32'h100);

    // T7: random traffic against the reference model
    lat_min = 1; lat_max = 4; ready_pct = 70; redir_pct = 3;
    apply_reset(1'b0);
    c0 = n_consumed;
    repeat (3000) step();
    check_eq("t7_progress", 32'(n_consumed - c0 > 300), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
